// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline (master) and hazard_ctrl (slave).
// Carries the IF/ID and ID/EX hazard fields plus the stall/flush controls and perf counters.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       idRs;
  logic [4:0]       idRt;
  logic             idUsesRt;
  logic             exMemRead;
  logic [4:0]       exRt;
  logic             branchTaken;
  logic             mcBusy;
  logic             hazardOutIFID;
  logic             flush;
  logic             pcWrite;
  logic             idExBubble;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output idRs, idRt, idUsesRt, exMemRead, exRt, branchTaken, mcBusy,
    input  hazardOutIFID, flush, pcWrite, idExBubble, stallCount, flushCount
  );

  modport slave (
    input  idRs, idRt, idUsesRt, exMemRead, exRt, branchTaken, mcBusy,
    output hazardOutIFID, flush, pcWrite, idExBubble, stallCount, flushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush control for the 5-stage pipeline: load-use, branch flush and SAD-busy hold.
// Performance counters exist only when HAZARD_PERF_CNT_EN is defined; otherwise they read 0.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StLuStall = 2'd1;
  localparam logic [1:0] StFlush   = 2'd2;
  localparam logic [1:0] StMcWait  = 2'd3;

  localparam logic [1:0] FlushReload = 2'(FLUSH_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic       load_use;
  logic       hazard_out, flush_out, pc_write, id_ex_bubble;

  assign load_use = hz.exMemRead && (hz.exRt != 5'd0) &&
                    ((hz.exRt == hz.idRs) || (hz.idUsesRt && (hz.exRt == hz.idRt)));

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    hazard_out   = 1'b0;
    flush_out    = 1'b0;
    pc_write     = 1'b1;
    id_ex_bubble = 1'b0;

    // A taken branch wins in every state and restarts the flush sequence.
    if (hz.branchTaken) begin
      flush_out    = 1'b1;
      id_ex_bubble = 1'b1;
      fcnt_d       = FlushReload;
      state_d      = (FLUSH_CYCLES > 1) ? StFlush : StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (hz.mcBusy) begin
            hazard_out = 1'b1;
            pc_write   = 1'b0;
            state_d    = StMcWait;
          end else if (load_use) begin
            hazard_out   = 1'b1;
            pc_write     = 1'b0;
            id_ex_bubble = 1'b1;
            state_d      = StLuStall;
          end
        end
        StLuStall: state_d = StRun;
        StFlush: begin
          flush_out    = 1'b1;
          id_ex_bubble = 1'b1;
          fcnt_d       = fcnt_q - 2'd1;
          if (fcnt_q <= 2'd1) state_d = StRun;
        end
        StMcWait: begin
          if (hz.mcBusy) begin
            hazard_out = 1'b1;
            pc_write   = 1'b0;
          end else begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      fcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign hz.hazardOutIFID = hazard_out;
  assign hz.flush         = flush_out;
  assign hz.pcWrite       = pc_write;
  assign hz.idExBubble    = id_ex_bubble;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: hold at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard_out && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (hz.branchTaken && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stallCount = stall_cnt_q;
  assign hz.flushCount = flush_cnt_q;
`else
  assign hz.stallCount = '0;
  assign hz.flushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (FLUSH_CYCLES=2/CNT_W=16 and FLUSH_CYCLES=3/CNT_W=4)
// share stimulus; directed table, corner sequences and random traffic against a reference model.
module tb_hazard_ctrl;

  localparam int FC_A = 2;
  localparam int FC_B = 3;
  localparam int CW_A = 16;
  localparam int CW_B = 4;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW_A)) if_a ();
  hazard_ctrl_if #(.CNT_W(CW_B)) if_b ();

  hazard_ctrl #(.FLUSH_CYCLES(FC_A), .CNT_W(CW_A)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if_a.slave)
  );

  hazard_ctrl #(.FLUSH_CYCLES(FC_B), .CNT_W(CW_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if_b.slave)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       mem_rd;
    logic [4:0] ex_rt;
    logic       bt;
    logic       mc;
    logic       e_hz;
    logic       e_fl;
    logic       e_pcw;
    logic       e_bub;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  // Current stimulus, mirrored into both interfaces.
  logic [4:0] in_rs, in_rt, in_ex_rt;
  logic       in_uses_rt, in_mem_rd, in_bt, in_mc;

  // Reference model: remaining flush cycles, waiting-on-SAD flag, load-use mask flag.
  int m_rem[2];
  bit m_mcw[2];
  bit m_lus[2];
  int m_sc[2];
  int m_fc[2];
  bit m_hz[2], m_fl[2], m_pcw[2], m_bub[2];
  int m_fcyc[2] = '{FC_A, FC_B};
  int m_max[2]  = '{(1 << CW_A) - 1, (1 << CW_B) - 1};

  function automatic vec_t mk(int rs, int rt, int ur, int mr, int ert, int bt, int mc,
                              int h, int f, int p, int b);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = ur[0]; v.mem_rd = mr[0]; v.ex_rt = 5'(ert);
    v.bt = bt[0]; v.mc = mc[0]; v.e_hz = h[0]; v.e_fl = f[0]; v.e_pcw = p[0]; v.e_bub = b[0];
    return v;
  endfunction

  function automatic int exp_cnt(int v);
    return PerfEn ? v : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input int rs, input int rt, input int ur, input int mr, input int ert,
                       input int bt, input int mc);
    in_rs = 5'(rs); in_rt = 5'(rt); in_uses_rt = ur[0]; in_mem_rd = mr[0];
    in_ex_rt = 5'(ert); in_bt = bt[0]; in_mc = mc[0];
    if_a.idRs = in_rs; if_a.idRt = in_rt; if_a.idUsesRt = in_uses_rt;
    if_a.exMemRead = in_mem_rd; if_a.exRt = in_ex_rt; if_a.branchTaken = in_bt;
    if_a.mcBusy = in_mc;
    if_b.idRs = in_rs; if_b.idRt = in_rt; if_b.idUsesRt = in_uses_rt;
    if_b.exMemRead = in_mem_rd; if_b.exRt = in_ex_rt; if_b.branchTaken = in_bt;
    if_b.mcBusy = in_mc;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rem[d] = 0; m_mcw[d] = 1'b0; m_lus[d] = 1'b0; m_sc[d] = 0; m_fc[d] = 0;
    end
  endtask

  task automatic model_comb();
    bit lu;
    lu = in_mem_rd && (in_ex_rt != 0) &&
         ((in_ex_rt == in_rs) || (in_uses_rt && (in_ex_rt == in_rt)));
    for (int d = 0; d < 2; d++) begin
      m_hz[d] = 1'b0; m_fl[d] = 1'b0; m_pcw[d] = 1'b1; m_bub[d] = 1'b0;
      if (in_bt || (m_rem[d] > 0)) begin
        m_fl[d] = 1'b1; m_bub[d] = 1'b1;
      end else if (m_mcw[d] || (!m_lus[d] && in_mc)) begin
        if (in_mc) begin m_hz[d] = 1'b1; m_pcw[d] = 1'b0; end
      end else if (!m_lus[d] && lu) begin
        m_hz[d] = 1'b1; m_pcw[d] = 1'b0; m_bub[d] = 1'b1;
      end
    end
  endtask

  task automatic model_seq();
    bit lu;
    lu = in_mem_rd && (in_ex_rt != 0) &&
         ((in_ex_rt == in_rs) || (in_uses_rt && (in_ex_rt == in_rt)));
    for (int d = 0; d < 2; d++) begin
      if (m_hz[d] && (m_sc[d] < m_max[d])) m_sc[d]++;
      if (in_bt && (m_fc[d] < m_max[d])) m_fc[d]++;
      if (in_bt) begin
        m_rem[d] = m_fcyc[d] - 1; m_mcw[d] = 1'b0; m_lus[d] = 1'b0;
      end else if (m_rem[d] > 0) begin
        m_rem[d]--;
      end else if (m_mcw[d]) begin
        m_mcw[d] = in_mc;
      end else if (m_lus[d]) begin
        m_lus[d] = 1'b0;
      end else if (in_mc) begin
        m_mcw[d] = 1'b1;
      end else if (lu) begin
        m_lus[d] = 1'b1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_comb();
  endtask

  task automatic advance();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic compare_model();
    check("a_hazardOutIFID", int'(if_a.hazardOutIFID), int'(m_hz[0]));
    check("a_flush",         int'(if_a.flush),         int'(m_fl[0]));
    check("a_pcWrite",       int'(if_a.pcWrite),       int'(m_pcw[0]));
    check("a_idExBubble",    int'(if_a.idExBubble),    int'(m_bub[0]));
    check("a_stallCount",    int'(if_a.stallCount),    exp_cnt(m_sc[0]));
    check("a_flushCount",    int'(if_a.flushCount),    exp_cnt(m_fc[0]));
    check("b_hazardOutIFID", int'(if_b.hazardOutIFID), int'(m_hz[1]));
    check("b_flush",         int'(if_b.flush),         int'(m_fl[1]));
    check("b_pcWrite",       int'(if_b.pcWrite),       int'(m_pcw[1]));
    check("b_idExBubble",    int'(if_b.idExBubble),    int'(m_bub[1]));
    check("b_stallCount",    int'(if_b.stallCount),    exp_cnt(m_sc[1]));
    check("b_flushCount",    int'(if_b.flushCount),    exp_cnt(m_fc[1]));
  endtask

  vec_t tbl[14];

  initial begin
    // Directed sequence for instance A (FLUSH_CYCLES=2), starting from RUN after reset.
    tbl[0]  = mk(5, 0, 0, 1, 5, 0, 0,  1, 0, 0, 1);  // load-use via rs
    tbl[1]  = mk(5, 0, 0, 1, 5, 0, 0,  0, 0, 1, 0);  // masked second cycle
    tbl[2]  = mk(0, 7, 0, 1, 7, 0, 0,  0, 0, 1, 0);  // rt match, rt unused
    tbl[3]  = mk(0, 7, 1, 1, 7, 0, 0,  1, 0, 0, 1);  // rt match, rt used
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
    tbl[5]  = mk(0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 0);  // r0 never stalls
    tbl[6]  = mk(5, 0, 0, 1, 5, 1, 0,  0, 1, 1, 1);  // branch beats load-use
    tbl[7]  = mk(5, 0, 0, 1, 5, 0, 0,  0, 1, 1, 1);  // second flush cycle
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0);  // SAD busy x3
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);

    // Reset: outputs idle, counters zero, asynchronously.
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_a_hazard",  int'(if_a.hazardOutIFID), 0);
    check("rst_a_pcWrite", int'(if_a.pcWrite), 1);
    check("rst_a_flush",   int'(if_a.flush), 0);
    check("rst_a_stall",   int'(if_a.stallCount), 0);
    check("rst_b_flushct", int'(if_b.flushCount), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].rs, tbl[i].rt, tbl[i].uses_rt, tbl[i].mem_rd, tbl[i].ex_rt, tbl[i].bt,
            tbl[i].mc);
      sample();
      check($sformatf("tbl%0d_hazard", i),  int'(if_a.hazardOutIFID), int'(tbl[i].e_hz));
      check($sformatf("tbl%0d_flush", i),   int'(if_a.flush),         int'(tbl[i].e_fl));
      check($sformatf("tbl%0d_pcWrite", i), int'(if_a.pcWrite),       int'(tbl[i].e_pcw));
      check($sformatf("tbl%0d_bubble", i),  int'(if_a.idExBubble),    int'(tbl[i].e_bub));
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    sample();
    check("tbl_stallCount", int'(if_a.stallCount), exp_cnt(5));
    check("tbl_flushCount", int'(if_a.flushCount), exp_cnt(1));
    compare_model();
    advance();

    // Reset in the middle of instance B's 3-cycle flush.
    drive(0, 0, 0, 0, 0, 1, 0);
    sample();
    check("rflush_c1_flush", int'(if_b.flush), 1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    sample();
    check("rflush_c2_flush", int'(if_b.flush), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rflush_async_flush",  int'(if_b.flush), 0);
    check("rflush_async_pcw",    int'(if_b.pcWrite), 1);
    check("rflush_async_bubble", int'(if_b.idExBubble), 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    sample();
    check("rflush_post_flush",   int'(if_b.flush), 0);
    check("rflush_post_stall",   int'(if_b.stallCount), 0);
    check("rflush_post_flushct", int'(if_b.flushCount), 0);
    compare_model();
    advance();

    // SAD busy for 20 cycles: A counts 20, B saturates at 15.
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      sample();
      check("sat_b_hazard", int'(if_b.hazardOutIFID), 1);
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    sample();
    check("sat_b_idle_hazard", int'(if_b.hazardOutIFID), 0);
    check("sat_a_stallCount",  int'(if_a.stallCount), exp_cnt(20));
    check("sat_b_stallCount",  int'(if_b.stallCount), exp_cnt(15));
    advance();

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      bit mc;
      mc = ($urandom_range(0, 5) == 0) ? !in_mc : in_mc;
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 7) == 0), mc);
      sample();
      compare_model();
      check("rnd_excl_a", int'(if_a.flush && if_a.hazardOutIFID), 0);
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
